// File: rtl/rtype_encoder_if.sv
// Request and instruction-memory write bundle for the R-type encoder.
// Latency: none, this is wiring only.
// Backpressure: in_ready and mem_ready travel with the signals they qualify.
interface rtype_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic        mem_we;
    logic        mem_ready;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [4:0]  count;
    logic        wrapped;

    // Requester side: offers ALU ops and acts as the instruction memory.
    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, wrapped
    );

    // Encoder side.
    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, count, wrapped
    );
endinterface

// File: rtl/rtype_encoder.sv
// Small synchronous FIFO with registered occupancy, used to queue encoded words.
// Latency: a pushed word is visible at head_dat one cycle after the push edge when empty.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module rtype_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [4:0]       count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_dat;
    end

    assign head_dat = store[rd_ptr];
endmodule

// Encodes ALU-op requests into MIPS R-type words and writes them to sequential instruction-memory addresses.
// Latency: one cycle from accept into an empty queue to mem_we, through a DEPTH-entry FIFO.
// Backpressure: in_ready drops only when the FIFO is full; mem_ready=0 holds the write head and address in place.
module rtype_encoder #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst,
    rtype_encoder_if.slave    bus
);
    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } rtype_t;

    rtype_t      enc;
    logic [31:0] head_dat;
    logic [4:0]  count;
    logic        push;
    logic        pop;
    logic [7:0]  addr_q;
    logic        wrapped_q;

    // Build the R-type word; nop (and anything unmapped) becomes an all-zero word.
    always_comb begin
        enc       = '0;
        enc.rs    = bus.in_rs;
        enc.rt    = bus.in_rt;
        enc.rd    = bus.in_rd;
        case (bus.in_op)
            3'b010:  enc.funct = 6'h20;
            3'b110:  enc.funct = 6'h22;
            3'b111:  enc.funct = 6'h2A;
            3'b000:  enc.funct = 6'h24;
            3'b001:  enc.funct = 6'h25;
            3'b101:  enc.funct = 6'h26;
            3'b100:  enc.funct = 6'h27;
            default: enc       = '0;
        endcase
    end

    // Readiness comes from registered occupancy only, so a same-cycle write never frees a full slot.
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.mem_we && bus.mem_ready;

    rtype_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (enc),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (count)
    );

    // Write address advances once per completed write; wrapped latches the FF->00 rollover.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= BASE_ADDR;
            wrapped_q <= 1'b0;
        end else if (pop) begin
            addr_q <= addr_q + 8'd1;
            if (addr_q == 8'hFF) wrapped_q <= 1'b1;
        end
    end

    assign bus.count     = count;
    assign bus.in_ready  = (count != 5'(DEPTH));
    assign bus.mem_we    = (count != 5'd0);
    assign bus.mem_wdata = bus.mem_we ? head_dat : 32'h0;
    assign bus.mem_addr  = addr_q;
    assign bus.wrapped   = wrapped_q;
endmodule
